chaos_keystream_gen: RTL and testbench
======================================

# chaos_keystream_gen

Parametrised, multi-channel chaotic keystream generator that drives the chaos-code PIO set of the encryption system. It answers the step/reset/shift handshake and returns one OUT_W-bit value per channel, generalising the fixed four-channel 8-bit x/y/z/w datapath. Channel count, state width, output width and iterations per step are parameters, and an optional LFSR perturbation breaks the short cycles that finite-precision chaotic maps fall into.

## Interface
- N_CH, 4: number of coupled channels (≥2); channels 0..3 map to x, y, z, w.
- STATE_W, 32: internal state width per channel (≥8).
- OUT_W, 8: output width per channel (≤ STATE_W).
- ITER, 16: map iterations per step request (≥1).
- COUPLE_ROT, 3: left-rotate amount applied to the coupling term (< STATE_W).
- clk_clk  in  1  system clock, the only clock.
- reset_reset  in  1  synchronous, active-high reset.
- chaos_reset  in  1  level; reseed from chaos_shift (PIO reset export).
- chaos_shift  in  32  seed word (PIO shift export).
- chaos_step  in  1  rising edge requests one step of ITER iterations.
- chaos_done  out  1  high when chaos_out holds the result of the latest step.
- chaos_out  out  N_CH*OUT_W  channel i at [i*OUT_W +: OUT_W].

## Operation
- Seed: rep = chaos_shift replicated and truncated to STATE_W bits. seed_i = rotl(rep, (8*i) mod STATE_W) ^ (i+1). A zero result is replaced by 1.
- Tent map on unsigned STATE_W: t(s) = s[MSB] ? (~s)<<1 : s<<1, truncated to STATE_W.
- Iteration: all channels update together from the old states. s_i' = t(s_i) ^ rotl(s_((i+1) mod N_CH), COUPLE_ROT). A zero s_i' is replaced by 1 (zero guard).
- Output fold: out_i = s_i[OUT_W-1:0] ^ s_i[STATE_W-1 -: OUT_W].
- FSM IDLE:
  - On a step edge (chaos_step=1 with step_q=0): cnt←ITER-1, chaos_done←0, go to RUN.
- FSM RUN:
  - Performs one iteration per cycle.
  - When cnt==0: chaos_out←fold of the new states, chaos_done←1, go to IDLE.
  - Otherwise cnt←cnt-1.
- step_q registers chaos_step every cycle in every state. Step edges arriving in RUN are dropped and not queued.
- chaos_reset (level, any state): states←seed(chaos_shift), chaos_done←0, go to IDLE, cnt←0. chaos_out holds its value.
- Priority: reset_reset > chaos_reset > step edge.

## Timing
- Values after reset_reset:
  - states = seed(0), i.e. s_i = i+1.
  - chaos_done=0, chaos_out=0, FSM=IDLE, cnt=0.
  - step_q=1, so a step held high through reset is not treated as an edge.
- Step latency: the step edge is sampled at clock edge E0. Iterations occur at E1..E_ITER. chaos_done and chaos_out update at E_ITER, ITER cycles after E0.
- Minimum step spacing: ITER+1 cycles, because a new edge is accepted only in IDLE.
- If chaos_reset asserts while in RUN, the step is aborted in that cycle. chaos_done stays 0 until a later step completes.
- If chaos_reset and a step edge occur together, the reseed wins and the step is dropped. The edge is consumed because step_q still updates.
- If a step edge arrives in the same cycle RUN finishes, it is ignored.

## Configuration
- CHAOS_PERTURB_EN defined:
  - Adds a 16-bit Fibonacci LFSR with taps 16, 14, 13, 11.
  - The LFSR loads 0xACE1 on reset_reset or chaos_reset and advances once per iteration.
  - Its current bit 0 is XORed into bit 0 of every s_i' before the zero guard.
- CHAOS_PERTURB_EN undefined: no LFSR is present. The map is purely deterministic as described in Operation.

## Test plan
- Reset: hold chaos_step=1 through reset_reset, then keep it high. Required: chaos_done=0 and chaos_out=0 indefinitely, no step starts.
- ITER=1, default parameters, macro off, shift=0, one step pulse. Required: states become 0x12, 0x1C, 0x26, 0x1 (ch3 exercises the zero guard). chaos_done=1 one cycle after the sampled edge. chaos_out=0x01261C12.
- ITER=16, step held high for 40 cycles. Required: exactly one step executes. chaos_done rises 16 cycles after the edge.
- Assert chaos_reset with shift=0 at RUN cycle 5, then issue a new step. Required: chaos_done stays 0 through the abort. The result matches a fresh step from seed(0).
- Repeat the same shift and step sequence twice, with chaos_reset between runs. Required: identical chaos_out sequences in both runs (macro off and macro on). The macro-on sequence differs from the macro-off sequence.
- Issue a step edge during RUN and one in the same cycle chaos_reset is asserted. Required: neither edge produces a step. chaos_done timing is unaffected.

Source files
------------

// File: rtl/chaos_keystream_gen.sv
// -----------------------------------------------------------------------------
// chaos_keystream_gen
//
// Multi-channel coupled tent-map keystream generator. Each step request runs
// ITER map iterations over N_CH coupled STATE_W-bit channels and then publishes
// one OUT_W-bit folded value per channel.
//
// Ports:
//   clk_clk      in   1            system clock (only clock)
//   reset_reset  in   1            synchronous active-high reset
//   chaos_reset  in   1            level: reseed all channels from chaos_shift
//   chaos_shift  in   32           seed word
//   chaos_step   in   1            rising edge requests one step of ITER iterations
//   chaos_done   out  1            chaos_out holds the result of the latest step
//   chaos_out    out  N_CH*OUT_W   channel i at [i*OUT_W +: OUT_W]
//
// Build option:
//   CHAOS_PERTURB_EN  when defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11,
//                     seeded 0xACE1) perturbs bit 0 of every new channel state
//                     once per iteration to break short finite-precision cycles.
// -----------------------------------------------------------------------------
module chaos_keystream_gen #(
  parameter int N_CH       = 4,
  parameter int STATE_W    = 32,
  parameter int OUT_W      = 8,
  parameter int ITER       = 16,
  parameter int COUPLE_ROT = 3
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset,
  input  logic                   chaos_reset,
  input  logic [31:0]            chaos_shift,
  input  logic                   chaos_step,
  output logic                   chaos_done,
  output logic [N_CH*OUT_W-1:0]  chaos_out
);

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  typedef logic [STATE_W-1:0]            state_t;
  typedef logic [N_CH-1:0][STATE_W-1:0]  bank_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fsm_t;

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------

  // Left rotate by a constant-per-call amount (bitwise loop keeps amt==0 safe).
  function automatic state_t rotl(input state_t s, input int amt);
    state_t r;
    r = '0;
    for (int j = 0; j < STATE_W; j++) begin
      r[(j + amt) % STATE_W] = s[j];
    end
    return r;
  endfunction

  // All-zero is a fixed point of the coupled map, so it is never allowed.
  function automatic state_t zero_guard(input state_t s);
    return (s == '0) ? state_t'(1'b1) : s;
  endfunction

  function automatic state_t tent(input state_t s);
    return s[STATE_W-1] ? ((~s) << 1) : (s << 1);
  endfunction

  function automatic state_t next_ch(input state_t s_self, input state_t s_nb,
                                     input logic pert);
    state_t v;
    v    = tent(s_self) ^ rotl(s_nb, COUPLE_ROT);
    v[0] = v[0] ^ pert;
    return zero_guard(v);
  endfunction

  // Seed word is replicated to fill STATE_W, then each channel gets its own
  // byte rotation and index so channels never start identical.
  function automatic bank_t seed_bank(input logic [31:0] shift);
    state_t rep;
    bank_t  b;
    for (int j = 0; j < STATE_W; j++) begin
      rep[j] = shift[j % 32];
    end
    for (int i = 0; i < N_CH; i++) begin
      b[i] = zero_guard(rotl(rep, (8 * i) % STATE_W) ^ state_t'(i + 1));
    end
    return b;
  endfunction

  function automatic logic [OUT_W-1:0] fold(input state_t s);
    return s[OUT_W-1:0] ^ s[STATE_W-1 -: OUT_W];
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  fsm_t                   r_fsm, w_fsm_nx;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nx;
  bank_t                  r_state, w_state_nx, w_iter;
  logic                   r_done, w_done_nx;
  logic [N_CH*OUT_W-1:0]  r_out, w_out_nx, w_fold;
  logic                   r_step_q;
  logic                   w_step_edge;
  logic                   w_pert;

`ifdef CHAOS_PERTURB_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  logic [15:0] r_lfsr, w_lfsr_nx;

  assign w_pert = r_lfsr[0];
`else
  assign w_pert = 1'b0;
`endif

  assign w_step_edge = chaos_step & ~r_step_q;
  assign chaos_done  = r_done;
  assign chaos_out   = r_out;

  // One map iteration of all channels from the current (old) states, plus fold.
  always_comb begin
    w_iter = '0;
    w_fold = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_iter[i] = next_ch(r_state[i], r_state[(i + 1) % N_CH], w_pert);
      w_fold[i*OUT_W +: OUT_W] = fold(w_iter[i]);
    end
  end

  // Next-state logic: reseed overrides the FSM; step edges only start in IDLE.
  always_comb begin
    w_fsm_nx   = r_fsm;
    w_cnt_nx   = r_cnt;
    w_state_nx = r_state;
    w_done_nx  = r_done;
    w_out_nx   = r_out;
`ifdef CHAOS_PERTURB_EN
    w_lfsr_nx  = r_lfsr;
`endif
    if (chaos_reset) begin
      w_state_nx = seed_bank(chaos_shift);
      w_done_nx  = 1'b0;
      w_fsm_nx   = ST_IDLE;
      w_cnt_nx   = '0;
`ifdef CHAOS_PERTURB_EN
      w_lfsr_nx  = LFSR_SEED;
`endif
    end else begin
      case (r_fsm)
        ST_IDLE: begin
          if (w_step_edge) begin
            w_cnt_nx  = CNT_LAST;
            w_done_nx = 1'b0;
            w_fsm_nx  = ST_RUN;
          end else begin
            w_fsm_nx  = ST_IDLE;
          end
        end
        ST_RUN: begin
          w_state_nx = w_iter;
`ifdef CHAOS_PERTURB_EN
          w_lfsr_nx  = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
`endif
          if (r_cnt == '0) begin
            w_out_nx  = w_fold;
            w_done_nx = 1'b1;
            w_fsm_nx  = ST_IDLE;
          end else begin
            w_cnt_nx  = r_cnt - CNT_W'(1);
          end
        end
        default: begin
          w_fsm_nx = ST_IDLE;
          w_cnt_nx = '0;
        end
      endcase
    end
  end

  // Register bank; step_q resets high so a step held through reset is no edge.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_fsm    <= ST_IDLE;
      r_cnt    <= '0;
      r_state  <= seed_bank(32'd0);
      r_done   <= 1'b0;
      r_out    <= '0;
      r_step_q <= 1'b1;
`ifdef CHAOS_PERTURB_EN
      r_lfsr   <= LFSR_SEED;
`endif
    end else begin
      r_fsm    <= w_fsm_nx;
      r_cnt    <= w_cnt_nx;
      r_state  <= w_state_nx;
      r_done   <= w_done_nx;
      r_out    <= w_out_nx;
      r_step_q <= chaos_step;
`ifdef CHAOS_PERTURB_EN
      r_lfsr   <= w_lfsr_nx;
`endif
    end
  end

endmodule

// File: tb/tb_chaos_keystream_gen.sv
// -----------------------------------------------------------------------------
// Testbench for chaos_keystream_gen. Two instances share stimulus: one with
// ITER=1 (hand-computed single/double step vectors) and one with ITER=16
// (latency, abort, repeatability and dropped-edge sequences).
// -----------------------------------------------------------------------------
module tb_chaos_keystream_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        creset;
  logic [31:0] shift;
  logic        step;
  logic        done1, done16;
  logic [31:0] out1, out16;

  int n_chk  = 0;
  int n_pass = 0;

`ifdef CHAOS_PERTURB_EN
  localparam bit PERT = 1'b1;
`else
  localparam bit PERT = 1'b0;
`endif

  always #5 clk = ~clk;

  chaos_keystream_gen #(.N_CH(4), .STATE_W(32), .OUT_W(8), .ITER(1), .COUPLE_ROT(3)) u_dut1 (
    .clk_clk     (clk),
    .reset_reset (rst),
    .chaos_reset (creset),
    .chaos_shift (shift),
    .chaos_step  (step),
    .chaos_done  (done1),
    .chaos_out   (out1)
  );

  chaos_keystream_gen #(.N_CH(4), .STATE_W(32), .OUT_W(8), .ITER(16), .COUPLE_ROT(3)) u_dut16 (
    .clk_clk     (clk),
    .reset_reset (rst),
    .chaos_reset (creset),
    .chaos_shift (shift),
    .chaos_step  (step),
    .chaos_done  (done16),
    .chaos_out   (out16)
  );

  // ---------------------------------------------------------------------------
  // Reference model (4 channels, 32-bit state, 8-bit fold, rotate 3)
  // ---------------------------------------------------------------------------
  logic [31:0] m_s [4];
  logic [15:0] m_l;

  task automatic m_seed(input logic [31:0] sh);
    logic [63:0] dbl;
    dbl = {sh, sh};
    for (int i = 0; i < 4; i++) begin
      m_s[i] = dbl[(32 - 8*i) +: 32] ^ (i + 1);
      if (m_s[i] == 32'd0) m_s[i] = 32'd1;
    end
    m_l = 16'hACE1;
  endtask

  task automatic m_run(input int n, input bit pert);
    logic [31:0] ns [4];
    logic [31:0] t, nb;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 4; i++) begin
        t  = (m_s[i] ^ {32{m_s[i][31]}}) << 1;
        nb = {m_s[(i+1)%4][28:0], m_s[(i+1)%4][31:29]};
        ns[i] = t ^ nb;
        if (pert) ns[i][0] = ns[i][0] ^ m_l[0];
        if (ns[i] == 32'd0) ns[i] = 32'd1;
      end
      for (int i = 0; i < 4; i++) m_s[i] = ns[i];
      if (pert) m_l = {m_l[14:0], m_l[15] ^ m_l[13] ^ m_l[12] ^ m_l[10]};
    end
  endtask

  function automatic logic [31:0] m_out();
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = m_s[i][7:0] ^ m_s[i][31:24];
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic check_ne(input string name, input logic [31:0] act, input logic [31:0] other);
    n_chk++;
    if (act !== other) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected anything but 0x%08h", name, act, other);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reseed(input logic [31:0] sh);
    shift  = sh;
    creset = 1'b1;
    tick();
    creset = 1'b0;
  endtask

  // ITER=1 vectors: hand-computed outputs of nsteps steps from seed(shift)
  typedef struct {
    logic [31:0] shift;
    int          nsteps;
    logic [31:0] exp_out;
  } vec_t;

  vec_t        vecs [5];
  logic [31:0] exp_v, exp16, exp_b;
  logic [31:0] runs [2][2];
  int          lat;

  initial begin
    vecs[0] = '{32'h0000_0000, 1, 32'h0126_1C12};  // ch3 hits the zero guard
    vecs[1] = '{32'h0000_0000, 2, 32'h9244_08C4};
    vecs[2] = '{32'h0000_0001, 1, 32'h022E_1C12};
    vecs[3] = '{32'h8000_0000, 1, 32'h0522_1C13};
    vecs[4] = '{32'hFFFF_FFFF, 1, 32'h0026_1C12};  // ch3 all-ones, no guard

    // Reset with step held high: no step may ever start
    rst = 1'b1; creset = 1'b0; step = 1'b1; shift = 32'd0;
    repeat (3) tick();
    check("rst_done1", {31'd0, done1}, 32'd0);
    check("rst_out1", out1, 32'd0);
    check("rst_done16", {31'd0, done16}, 32'd0);
    check("rst_out16", out16, 32'd0);
    rst = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k % 20 == 0) begin
        check("held_done1", {31'd0, done1}, 32'd0);
        check("held_done16", {31'd0, done16}, 32'd0);
        check("held_out1", out1, 32'd0);
      end
    end
    step = 1'b0;
    tick();

    // Table-driven ITER=1 vectors
    for (int v = 0; v < 5; v++) begin
      reseed(vecs[v].shift);
      check("reseed_done1", {31'd0, done1}, 32'd0);
      m_seed(vecs[v].shift);
      for (int s = 0; s < vecs[v].nsteps; s++) begin
        step = 1'b1;
        tick();
        check("i1_done_e0", {31'd0, done1}, 32'd0);
        tick();
        check("i1_done_e1", {31'd1 & 32'd0, done1}, 32'd1);
        m_run(1, PERT);
        if (s == vecs[v].nsteps - 1) begin
`ifdef CHAOS_PERTURB_EN
          exp_v = m_out();
`else
          exp_v = vecs[v].exp_out;
`endif
          check("i1_out", out1, exp_v);
        end
        step = 1'b0;
        tick();
      end
    end

    // ITER=16: step held high 40 cycles, exactly one step, latency 16
    reseed(32'd0);
    step = 1'b0;
    tick();
    m_seed(32'd0);
    m_run(16, PERT);
    exp16 = m_out();
    step = 1'b1;
    tick();
    check("i16_done_e0", {31'd0, done16}, 32'd0);
    lat = 0;
    while (done16 !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    check("i16_latency", lat, 32'd16);
    repeat (39 - lat) tick();
    check("i16_held_done", {31'd0, done16}, 32'd1);
    check("i16_held_out", out16, exp16);
    step = 1'b0;
    tick();

    // Abort with chaos_reset at RUN cycle 5, then a fresh step
    reseed(32'd0);
    step = 1'b1;
    tick();
    repeat (5) tick();
    creset = 1'b1;
    tick();
    check("abort_done", {31'd0, done16}, 32'd0);
    creset = 1'b0;
    step = 1'b0;
    repeat (20) tick();
    check("abort_done_later", {31'd0, done16}, 32'd0);
    step = 1'b1;
    tick();
    repeat (16) tick();
    check("abort_fresh_done", {31'd0, done16}, 32'd1);
    check("abort_fresh_out", out16, exp16);
    step = 1'b0;
    tick();

    // Repeatability: same seed and step sequence twice
    for (int r = 0; r < 2; r++) begin
      reseed(32'h1234_5678);
      for (int k = 0; k < 2; k++) begin
        step = 1'b1;
        tick();
        repeat (16) tick();
        step = 1'b0;
        tick();
        runs[r][k] = out16;
      end
    end
    check("repeat_k0", runs[1][0], runs[0][0]);
    check("repeat_k1", runs[1][1], runs[0][1]);
    m_seed(32'h1234_5678);
    m_run(16, PERT);
    check("repeat_model_k0", runs[0][0], m_out());
    m_run(16, PERT);
    check("repeat_model_k1", runs[0][1], m_out());
`ifdef CHAOS_PERTURB_EN
    m_seed(32'h1234_5678);
    m_run(16, 1'b0);
    check_ne("perturb_differs", runs[0][0], m_out());
`endif

    // Edge during RUN and edge on the finishing cycle are both dropped
    reseed(32'hA5A5_0F0F);
    m_seed(32'hA5A5_0F0F);
    m_run(16, PERT);
    exp_b = m_out();
    step = 1'b1;
    tick();                      // E0
    step = 1'b0;
    repeat (2) tick();           // E2
    step = 1'b1;
    tick();                      // E3: edge in RUN
    repeat (7) tick();           // E10
    step = 1'b0;
    repeat (5) tick();           // E15
    check("drop_done_e15", {31'd0, done16}, 32'd0);
    step = 1'b1;
    tick();                      // E16: finish, coincident edge
    check("drop_done_e16", {31'd0, done16}, 32'd1);
    check("drop_out_e16", out16, exp_b);
    repeat (20) tick();
    check("drop_done_late", {31'd0, done16}, 32'd1);
    check("drop_out_late", out16, exp_b);

    // Edge coincident with chaos_reset is consumed, output held
    step = 1'b0;
    tick();
    shift  = 32'hA5A5_0F0F;
    creset = 1'b1;
    step   = 1'b1;
    tick();
    creset = 1'b0;
    repeat (25) tick();
    check("reseed_edge_done", {31'd0, done16}, 32'd0);
    check("reseed_edge_out", out16, exp_b);
    step = 1'b0;
    tick();
    step = 1'b1;
    tick();
    repeat (15) tick();
    check("after_drop_e15", {31'd0, done16}, 32'd0);
    tick();
    check("after_drop_done", {31'd0, done16}, 32'd1);
    check("after_drop_out", out16, exp_b);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
